// File: rtl/drum_dot_sequencer.sv
// -----------------------------------------------------------------------------
// drum_dot_sequencer
//
// Sequencer for the 8-lane DRUM approximate dot-product datapath. Operand
// beats (8 IFM lanes + 8 weight lanes, 16 bits each) arrive over a
// valid/ready handshake. Each accepted beat is registered onto the datapath
// inputs. The 35-bit partial sum that the datapath returns in the following
// cycle is added into a wide accumulator. After a programmed number of beats,
// the accumulated dot product is presented with a valid/ready handshake.
//
// Optional feature macro: DRUM_ACC_SAT_EN
//   defined   : the accumulator saturates at 2^ACC_W-1 and Out_Overflow is a
//               sticky flag.
//   undefined : the accumulator wraps modulo 2^ACC_W and Out_Overflow
//               stays 0.
//
// Parameters
//   ACC_W  accumulator / result width (must be >= 35)
//   LEN_W  width of the beat-count field
//
// Ports
//   clk              clock, all state on the rising edge
//   rst              asynchronous active-high reset
//   In_Start         job start pulse, honoured only in IDLE
//   In_Len           beats in the job, sampled with In_Start (0 is legal)
//   In_Valid         operand beat valid
//   Out_Ready        operand beat accept (high only in RUN)
//   In_IFM_Bus       8 IFM lanes, lane k at [16k+15:16k]
//   In_Weight_Bus    8 weight lanes, same packing
//   Out_IFM_Bus      registered IFM lanes to the datapath
//   Out_Weight_Bus   registered weight lanes to the datapath
//   In_Psum          unsigned datapath sum of the 8 products
//   Out_Result       accumulated dot product
//   Out_Valid        result valid (DONE state)
//   In_Result_Ready  result consumed when Out_Valid & In_Result_Ready
//   Out_Busy         high in every state except IDLE
//   Out_Overflow     sticky accumulator overflow flag
// -----------------------------------------------------------------------------
module drum_dot_sequencer #(
   parameter int ACC_W = 43,
   parameter int LEN_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             In_Start,
   input  logic [LEN_W-1:0] In_Len,
   input  logic             In_Valid,
   output logic             Out_Ready,
   input  logic [127:0]     In_IFM_Bus,
   input  logic [127:0]     In_Weight_Bus,
   output logic [127:0]     Out_IFM_Bus,
   output logic [127:0]     Out_Weight_Bus,
   input  logic [34:0]      In_Psum,
   output logic [ACC_W-1:0] Out_Result,
   output logic             Out_Valid,
   input  logic             In_Result_Ready,
   output logic             Out_Busy,
   output logic             Out_Overflow
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t           state;
   logic [LEN_W-1:0] remaining;   // beats still to be accepted in this job
   logic             v1;          // datapath inputs hold a fresh beat this cycle
   logic [ACC_W-1:0] acc;
   logic             ovf;

   logic             accept;
   logic [ACC_W-1:0] psum_ext;
   logic [ACC_W-1:0] acc_next;
   logic             ovf_next;

   // Out_Ready is only ever high in RUN, so this is the complete accept term.
   assign accept   = In_Valid & Out_Ready;

   // Zero-extension of the unsigned partial sum; ACC_W is at least 35.
   assign psum_ext = ACC_W'(In_Psum);

`ifdef DRUM_ACC_SAT_EN
   // One extra bit catches the carry out of the true sum.
   logic [ACC_W:0] sum_wide;

   // NOTE: every signal written in always_comb gets a value on every path,
   // otherwise synthesis infers a latch to hold the old value.
   always_comb begin
      sum_wide = {1'b0, acc} + {1'b0, psum_ext};
      acc_next = sum_wide[ACC_W-1:0];
      ovf_next = 1'b0;
      if (sum_wide[ACC_W]) begin
         // Clamp; once at full scale, later adds carry again and stay clamped.
         acc_next = '1;
         ovf_next = 1'b1;
      end
   end
`else
   // Wrapping accumulator; the overflow register can never be set.
   always_comb begin
      acc_next = acc + psum_ext;
      ovf_next = 1'b0;
   end
`endif

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order in the block.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         remaining      <= '0;
         v1             <= 1'b0;
         acc            <= '0;
         ovf            <= 1'b0;
         Out_Ready      <= 1'b0;
         Out_Valid      <= 1'b0;
         Out_Busy       <= 1'b0;
         Out_IFM_Bus    <= '0;
         Out_Weight_Bus <= '0;
      end else begin
         // Stage flag follows the handshake; gaps clear it.
         v1 <= accept;

         // Datapath operand registers hold their value between beats.
         if (accept) begin
            Out_IFM_Bus    <= In_IFM_Bus;
            Out_Weight_Bus <= In_Weight_Bus;
         end

         // Accumulate in any state whenever the datapath carries a fresh beat.
         if (v1) begin
            acc <= acc_next;
            if (ovf_next) begin
               ovf <= 1'b1;
            end
         end

         case (state)
            IDLE: begin
               if (In_Start) begin
                  remaining <= In_Len;
                  acc       <= '0;     // v1 is never set in IDLE, so no add is lost
                  ovf       <= 1'b0;
                  Out_Busy  <= 1'b1;
                  if (In_Len == '0) begin
                     state     <= DONE;
                     Out_Valid <= 1'b1;
                  end else begin
                     state     <= RUN;
                     Out_Ready <= 1'b1;
                  end
               end
            end

            RUN: begin
               if (accept) begin
                  remaining <= remaining - LEN_W'(1);
                  if (remaining == LEN_W'(1)) begin
                     state     <= DRAIN;
                     Out_Ready <= 1'b0;
                  end
               end
            end

            // The last beat's psum is added on this edge (v1 is set).
            DRAIN: begin
               state     <= DONE;
               Out_Valid <= 1'b1;
            end

            // acc is stable here because v1 is always clear in DONE.
            DONE: begin
               if (In_Result_Ready) begin
                  state     <= IDLE;
                  Out_Valid <= 1'b0;
                  Out_Busy  <= 1'b0;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign Out_Result   = acc;
   assign Out_Overflow = ovf;

endmodule
